// File: rtl/instr_encoder_if.sv
// Request/write-port bundle for the instruction encoder.
// The master side issues encode requests; the slave side is the encoder.
interface instr_encoder_if #(
   parameter int AW = 10
);
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    kind;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [15:0]   imm;
   logic [25:0]   target;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;
   logic          full;
   logic          err;

   modport master (
      output in_valid, kind, rs, rt, rd, imm, target,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );

   modport slave (
      input  in_valid, kind, rs, rt, rd, imm, target,
      output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction descriptions into 32-bit words and writes
// them sequentially into an instruction memory of 2^AW words.
//
// state | meaning
// IDLE  | ready for a request (in_ready = 1)
// WRITE | one-cycle imem write strobe, count advances on exit
// FULL  | all 2^AW words written, requests refused until reset
module instr_encoder #(
   parameter int AW = 10
) (
   input  logic           clk,
   input  logic           rst,
   instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   state_t        state_q;
   logic          ready_q;
   logic          we_q;
   logic          full_q;
   logic          err_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_inc;
   logic [31:0]   word_d;
   logic          legal_d;

   assign count_inc = count_q + {{AW{1'b0}}, 1'b1};

   always_comb begin
      word_d  = '0;
      legal_d = 1'b1;
      case (bus.kind)
         4'd0:    word_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
         4'd1:    word_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100010};
         4'd2:    word_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100011};
         4'd3:    word_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b101010};
         4'd4:    word_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b101011};
         4'd5:    word_d = {6'b001101, bus.rs, bus.rt, bus.imm};
         4'd6:    word_d = {6'b001001, bus.rs, bus.rt, bus.imm};
         4'd7:    word_d = {6'b100011, bus.rs, bus.rt, bus.imm};
         4'd8:    word_d = {6'b101011, bus.rs, bus.rt, bus.imm};
         4'd9:    word_d = {6'b000100, bus.rs, bus.rt, bus.imm};
         4'd10:   word_d = {6'b000010, bus.target};
         default: legal_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (legal_d) begin
                     wdata_q <= word_d;
                     addr_q  <= count_q[AW-1:0];
                     we_q    <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= WRITE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               we_q    <= 1'b0;
               count_q <= count_inc;
               if (count_inc == DEPTH) begin
                  full_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= FULL;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            FULL: begin
               we_q    <= 1'b0;
               ready_q <= 1'b0;
               full_q  <= 1'b1;
            end
            default: begin
               we_q    <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Gating with rst keeps the memory from sampling a strobe on a reset edge.
   assign bus.imem_we    = we_q & ~rst;
   assign bus.in_ready   = ready_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.full       = full_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default-depth instance for encoding,
// plus an AW=2 instance sharing the same stimulus for the full condition.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  kind = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.AW(10)) ifa ();
   instr_encoder_if #(.AW(2))  ifb ();

   assign ifa.in_valid = in_valid;
   assign ifa.kind     = kind;
   assign ifa.rs       = rs;
   assign ifa.rt       = rt;
   assign ifa.rd       = rd;
   assign ifa.imm      = imm;
   assign ifa.target   = target;
   assign ifb.in_valid = in_valid;
   assign ifb.kind     = kind;
   assign ifb.rs       = rs;
   assign ifb.rt       = rt;
   assign ifb.rd       = rd;
   assign ifb.imm      = imm;
   assign ifb.target   = target;

   instr_encoder #(.AW(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   instr_encoder #(.AW(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a request at the falling edge; it is sampled on the next rising edge.
   task automatic drive(input logic [3:0] k, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [15:0] im, input logic [25:0] tg);
      @(negedge clk);
      kind = k; rs = a; rt = b; rd = c; imm = im; target = tg;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [10:0] exp_count;
      logic        exp_err;
      logic [31:0] last_word;
      logic [9:0]  last_addr;

      vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 1'b1, 32'h00221820};
      vecs[1]  = '{4'd7,  5'd0,  5'd8,  5'd0,  16'h0004, 26'h0000000, 1'b1, 32'h8C080004};
      vecs[2]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0000000, 1'b1, 32'h1022FFFF};
      vecs[3]  = '{4'd10, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000100, 1'b1, 32'h08000100};
      vecs[4]  = '{4'd12, 5'd1,  5'd1,  5'd1,  16'h1234, 26'h0000000, 1'b0, 32'h00000000};
      vecs[5]  = '{4'd5,  5'd0,  5'd1,  5'd0,  16'h00FF, 26'h0000000, 1'b1, 32'h340100FF};
      vecs[6]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0000000, 1'b1, 32'h00853022};
      vecs[7]  = '{4'd2,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0000000, 1'b1, 32'h03FFF823};
      vecs[8]  = '{4'd3,  5'd7,  5'd0,  5'd9,  16'h0000, 26'h0000000, 1'b1, 32'h00E0482A};
      vecs[9]  = '{4'd4,  5'd0,  5'd3,  5'd1,  16'hFFFF, 26'h0000000, 1'b1, 32'h0003082B};
      vecs[10] = '{4'd6,  5'd2,  5'd3,  5'd31, 16'h8000, 26'h0000000, 1'b1, 32'h24438000};
      vecs[11] = '{4'd8,  5'd29, 5'd31, 5'd0,  16'h0010, 26'h0000000, 1'b1, 32'hAFBF0010};
      vecs[12] = '{4'd11, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000000, 1'b0, 32'h00000000};
      vecs[13] = '{4'd10, 5'd5,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
      vecs[14] = '{4'd15, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000000, 1'b0, 32'h00000000};
      vecs[15] = '{4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000000, 1'b1, 32'h00000020};

      do_reset();
      #1;
      chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
      chk("rst_count",    32'(ifa.count), 32'd0);
      chk("rst_full",     32'(ifa.full), 32'd0);
      chk("rst_err",      32'(ifa.err), 32'd0);
      chk("rst_we",       32'(ifa.imem_we), 32'd0);
      chk("rst_addr",     32'(ifa.imem_addr), 32'd0);
      chk("rst_wdata",    ifa.imem_wdata, 32'd0);

      // No valid: junk fields must be ignored.
      kind = 4'd0; rs = 5'd9; imm = 16'hABCD;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_we",    32'(ifa.imem_we), 32'd0);
      chk("idle_count", 32'(ifa.count), 32'd0);
      chk("idle_ready", 32'(ifa.in_ready), 32'd1);

      exp_count = '0;
      exp_err   = 1'b0;
      last_word = '0;
      last_addr = '0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("v%0d_ready_before", i), 32'(ifa.in_ready), 32'd1);
         drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
         if (vecs[i].legal) begin
            chk($sformatf("v%0d_we", i),    32'(ifa.imem_we), 32'd1);
            chk($sformatf("v%0d_wdata", i), ifa.imem_wdata, vecs[i].word);
            chk($sformatf("v%0d_addr", i),  32'(ifa.imem_addr), 32'(exp_count));
            chk($sformatf("v%0d_ready_wr", i), 32'(ifa.in_ready), 32'd0);
            last_word = vecs[i].word;
            last_addr = exp_count[9:0];
            exp_count = exp_count + 11'd1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we_off", i), 32'(ifa.imem_we), 32'd0);
            chk($sformatf("v%0d_count", i),  32'(ifa.count), 32'(exp_count));
            chk($sformatf("v%0d_hold_wdata", i), ifa.imem_wdata, last_word);
         end else begin
            exp_err = 1'b1;
            chk($sformatf("v%0d_ill_we", i),    32'(ifa.imem_we), 32'd0);
            chk($sformatf("v%0d_ill_count", i), 32'(ifa.count), 32'(exp_count));
            chk($sformatf("v%0d_ill_wdata", i), ifa.imem_wdata, last_word);
            chk($sformatf("v%0d_ill_addr", i),  32'(ifa.imem_addr), 32'(last_addr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ill_we2", i),   32'(ifa.imem_we), 32'd0);
         end
         chk($sformatf("v%0d_ready_after", i), 32'(ifa.in_ready), 32'd1);
         chk($sformatf("v%0d_err", i), 32'(ifa.err), 32'(exp_err));
         chk($sformatf("v%0d_full", i), 32'(ifa.full), 32'd0);
      end

      // Reset has priority over a simultaneous handshake.
      @(negedge clk);
      rst = 1'b1;
      kind = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rstpri_we",    32'(ifa.imem_we), 32'd0);
      chk("rstpri_count", 32'(ifa.count), 32'd0);
      chk("rstpri_err",   32'(ifa.err), 32'd0);
      chk("rstpri_ready", 32'(ifa.in_ready), 32'd1);

      // Reset landing on the WRITE cycle cancels the write.
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
      chk("rstwr_we_pre", 32'(ifa.imem_we), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstwr_we_gated", 32'(ifa.imem_we), 32'd0);
      @(posedge clk);
      #1;
      chk("rstwr_count", 32'(ifa.count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstwr_we_post", 32'(ifa.imem_we), 32'd0);
      chk("rstwr_ready",   32'(ifa.in_ready), 32'd1);
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
      chk("rstwr_new_we",    32'(ifa.imem_we), 32'd1);
      chk("rstwr_new_addr",  32'(ifa.imem_addr), 32'd0);
      chk("rstwr_new_wdata", ifa.imem_wdata, 32'h00221820);
      @(posedge clk);
      #1;
      chk("rstwr_new_count", 32'(ifa.count), 32'd1);

      // Fill the AW=2 instance.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
         chk($sformatf("fill%0d_we", i),    32'(ifb.imem_we), 32'd1);
         chk($sformatf("fill%0d_addr", i),  32'(ifb.imem_addr), 32'(i));
         chk($sformatf("fill%0d_wdata", i), ifb.imem_wdata, vecs[i].word);
         @(posedge clk);
         #1;
         chk($sformatf("fill%0d_full", i), 32'(ifb.full), (i == 3) ? 32'd1 : 32'd0);
      end
      chk("full_count", 32'(ifb.count), 32'd4);
      chk("full_ready", 32'(ifb.in_ready), 32'd0);
      drive(4'd5, 5'd0, 5'd1, 5'd0, 16'h00FF, 26'h0);
      chk("full_5th_we", 32'(ifb.imem_we), 32'd0);
      @(posedge clk);
      #1;
      chk("full_5th_we2",   32'(ifb.imem_we), 32'd0);
      chk("full_5th_count", 32'(ifb.count), 32'd4);
      chk("full_5th_full",  32'(ifb.full), 32'd1);
      chk("full_5th_wdata", ifb.imem_wdata, vecs[3].word);
      do_reset();
      #1;
      chk("full_rst_full",  32'(ifb.full), 32'd0);
      chk("full_rst_ready", 32'(ifb.in_ready), 32'd1);
      chk("full_rst_count", 32'(ifb.count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
